// File: rtl/cache_bank_miss_handler.sv
// Miss retirement engine for one cache bank. It writes back a dirty victim, fetches the missing
// block one word per beat, merges buffered stores into it, fills the bank and pops the MSHR head.
module cache_bank_miss_handler #(
    parameter int WORD_W     = 32,
    parameter int BLOCK_SIZE = 4,
    parameter int ADDR_W     = 32,
    parameter int TAG_W      = 26,
    parameter int INDEX_W    = 2,
    parameter int UUID_SIZE  = 4
) (
    input  logic                         CLK,
    input  logic                         RST,

    input  logic                         mshr_valid,
    input  logic [UUID_SIZE-1:0]         mshr_uuid,
    input  logic [ADDR_W-1:0]            mshr_block_addr,
    input  logic [BLOCK_SIZE-1:0]        mshr_write_status,
    input  logic [BLOCK_SIZE*WORD_W-1:0] mshr_write_block,
    output logic                         bank_free,

    input  logic                         victim_valid,
    input  logic                         victim_dirty,
    input  logic [TAG_W-1:0]             victim_tag,
    input  logic [BLOCK_SIZE*WORD_W-1:0] victim_block,

    output logic                         mem_req_valid,
    input  logic                         mem_req_ready,
    output logic                         mem_req_rw,
    output logic [ADDR_W-1:0]            mem_req_addr,
    output logic [WORD_W-1:0]            mem_req_wdata,
    input  logic                         mem_resp_valid,
    input  logic [WORD_W-1:0]            mem_resp_rdata,

    output logic                         fill_en,
    output logic [INDEX_W-1:0]           fill_index,
    output logic [TAG_W-1:0]             fill_tag,
    output logic [BLOCK_SIZE*WORD_W-1:0] fill_block,
    output logic                         fill_dirty,
    output logic [UUID_SIZE-1:0]         done_uuid,
    output logic                         busy
);

    localparam int OFF_W = $clog2(BLOCK_SIZE);
    localparam int CNT_W = OFF_W + 1;
    localparam int BLK_W = BLOCK_SIZE * WORD_W;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLOCK_SIZE - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(BLOCK_SIZE);

    typedef enum logic [2:0] {
        IDLE,
        WB,
        FETCH,
        FILL,
        RETIRE
    } state_t;

    state_t r_state;
    state_t w_next_state;

    logic [UUID_SIZE-1:0]  r_uuid;
    logic [ADDR_W-1:0]     r_block_addr;
    logic [BLOCK_SIZE-1:0] r_write_status;
    logic [BLK_W-1:0]      r_write_block;
    logic [TAG_W-1:0]      r_victim_tag;
    logic [BLK_W-1:0]      r_victim_block;
    logic [BLK_W-1:0]      r_fetch_block;
    logic [CNT_W-1:0]      r_beat;
    logic [CNT_W-1:0]      r_rcv;

    logic [INDEX_W-1:0]    w_index;
    logic [TAG_W-1:0]      w_tag;
    logic [ADDR_W-1:0]     w_wb_addr;
    logic [ADDR_W-1:0]     w_fetch_addr;
    logic [WORD_W-1:0]     w_wb_word;
    logic [BLK_W-1:0]      w_merged;
    logic                  w_issue_open;
    logic                  w_req_fire;
    logic                  w_resp_take;

    assign w_tag        = r_block_addr[ADDR_W-1 -: TAG_W];
    assign w_index      = r_block_addr[OFF_W+2 +: INDEX_W];
    assign w_wb_addr    = {r_victim_tag, w_index, r_beat[OFF_W-1:0], 2'b00};
    assign w_fetch_addr = r_block_addr + ADDR_W'({r_beat[OFF_W-1:0], 2'b00});
    assign w_issue_open = (r_beat != CNT_FULL);
    assign w_req_fire   = mem_req_valid && mem_req_ready;
    assign w_resp_take  = (r_state == FETCH) && mem_resp_valid && (r_rcv != CNT_FULL);
    assign busy         = (r_state != IDLE);

    always_comb begin
        w_wb_word = '0;
        for (int i = 0; i < BLOCK_SIZE; i++) begin
            if (r_beat[OFF_W-1:0] == OFF_W'(i)) begin
                w_wb_word = r_victim_block[i*WORD_W +: WORD_W];
            end
        end
    end

    // Buffered store words take priority over the words fetched from memory.
    always_comb begin
        w_merged = '0;
        for (int i = 0; i < BLOCK_SIZE; i++) begin
            w_merged[i*WORD_W +: WORD_W] = r_write_status[i] ? r_write_block[i*WORD_W +: WORD_W]
                                                             : r_fetch_block[i*WORD_W +: WORD_W];
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state  = r_state;
        mem_req_valid = 1'b0;
        mem_req_rw    = 1'b0;
        mem_req_addr  = '0;
        mem_req_wdata = '0;
        fill_en       = 1'b0;
        fill_index    = '0;
        fill_tag      = '0;
        fill_block    = '0;
        fill_dirty    = 1'b0;
        bank_free     = 1'b0;
        done_uuid     = '0;
        case (r_state)
            IDLE: begin
                if (mshr_valid) begin
                    w_next_state = (victim_valid && victim_dirty) ? WB : FETCH;
                end
            end
            WB: begin
                mem_req_valid = 1'b1;
                mem_req_rw    = 1'b1;
                mem_req_addr  = w_wb_addr;
                mem_req_wdata = w_wb_word;
                if (mem_req_ready && (r_beat == CNT_LAST)) begin
                    w_next_state = FETCH;
                end
            end
            FETCH: begin
                mem_req_valid = w_issue_open;
                mem_req_addr  = w_issue_open ? w_fetch_addr : '0;
                if (w_resp_take && (r_rcv == CNT_LAST)) begin
                    w_next_state = FILL;
                end
            end
            FILL: begin
                fill_en      = 1'b1;
                fill_index   = w_index;
                fill_tag     = w_tag;
                fill_block   = w_merged;
                fill_dirty   = |r_write_status;
                w_next_state = RETIRE;
            end
            RETIRE: begin
                bank_free    = 1'b1;
                done_uuid    = r_uuid;
                w_next_state = IDLE;
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // The beat counter serves the writeback first and is rewound to drive the fetch issue.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_uuid         <= '0;
            r_block_addr   <= '0;
            r_write_status <= '0;
            r_write_block  <= '0;
            r_victim_tag   <= '0;
            r_victim_block <= '0;
            r_fetch_block  <= '0;
            r_beat         <= '0;
            r_rcv          <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (mshr_valid) begin
                        r_uuid         <= mshr_uuid;
                        r_block_addr   <= mshr_block_addr;
                        r_write_status <= mshr_write_status;
                        r_write_block  <= mshr_write_block;
                        r_victim_tag   <= victim_tag;
                        r_victim_block <= victim_block;
                        r_beat         <= '0;
                        r_rcv          <= '0;
                    end
                end
                WB: begin
                    if (mem_req_ready) begin
                        if (r_beat == CNT_LAST) begin
                            r_beat <= '0;
                        end else begin
                            r_beat <= r_beat + CNT_W'(1);
                        end
                    end
                end
                FETCH: begin
                    if (w_req_fire) begin
                        r_beat <= r_beat + CNT_W'(1);
                    end
                    if (w_resp_take) begin
                        r_rcv <= r_rcv + CNT_W'(1);
                        for (int i = 0; i < BLOCK_SIZE; i++) begin
                            if (r_rcv[OFF_W-1:0] == OFF_W'(i)) begin
                                r_fetch_block[i*WORD_W +: WORD_W] <= mem_resp_rdata;
                            end
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cache_bank_miss_handler.sv
// Scoreboard bench for cache_bank_miss_handler: directed entries push expected memory beats,
// fills and retirements; a negedge monitor pops and compares whatever the DUT presents.
module tb_cache_bank_miss_handler;

    localparam int WORD_W     = 32;
    localparam int BLOCK_SIZE = 4;
    localparam int ADDR_W     = 32;
    localparam int TAG_W      = 26;
    localparam int INDEX_W    = 2;
    localparam int UUID_SIZE  = 4;
    localparam int BLK_W      = BLOCK_SIZE * WORD_W;

    logic                 CLK = 1'b0;
    logic                 RST = 1'b1;
    logic                 mshr_valid;
    logic [UUID_SIZE-1:0] mshr_uuid;
    logic [ADDR_W-1:0]    mshr_block_addr;
    logic [3:0]           mshr_write_status;
    logic [BLK_W-1:0]     mshr_write_block;
    logic                 bank_free;
    logic                 victim_valid;
    logic                 victim_dirty;
    logic [TAG_W-1:0]     victim_tag;
    logic [BLK_W-1:0]     victim_block;
    logic                 mem_req_valid;
    logic                 mem_req_ready;
    logic                 mem_req_rw;
    logic [ADDR_W-1:0]    mem_req_addr;
    logic [WORD_W-1:0]    mem_req_wdata;
    logic                 mem_resp_valid;
    logic [WORD_W-1:0]    mem_resp_rdata;
    logic                 fill_en;
    logic [INDEX_W-1:0]   fill_index;
    logic [TAG_W-1:0]     fill_tag;
    logic [BLK_W-1:0]     fill_block;
    logic                 fill_dirty;
    logic [UUID_SIZE-1:0] done_uuid;
    logic                 busy;

    cache_bank_miss_handler #(
        .WORD_W(WORD_W), .BLOCK_SIZE(BLOCK_SIZE), .ADDR_W(ADDR_W),
        .TAG_W(TAG_W), .INDEX_W(INDEX_W), .UUID_SIZE(UUID_SIZE)
    ) dut (
        .CLK(CLK), .RST(RST),
        .mshr_valid(mshr_valid), .mshr_uuid(mshr_uuid), .mshr_block_addr(mshr_block_addr),
        .mshr_write_status(mshr_write_status), .mshr_write_block(mshr_write_block),
        .bank_free(bank_free),
        .victim_valid(victim_valid), .victim_dirty(victim_dirty),
        .victim_tag(victim_tag), .victim_block(victim_block),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_rw(mem_req_rw),
        .mem_req_addr(mem_req_addr), .mem_req_wdata(mem_req_wdata),
        .mem_resp_valid(mem_resp_valid), .mem_resp_rdata(mem_resp_rdata),
        .fill_en(fill_en), .fill_index(fill_index), .fill_tag(fill_tag),
        .fill_block(fill_block), .fill_dirty(fill_dirty),
        .done_uuid(done_uuid), .busy(busy)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic        rw;
        logic [31:0] addr;
        logic [31:0] wdata;
    } req_t;

    typedef struct {
        logic [1:0]   index;
        logic [25:0]  tag;
        logic [127:0] block;
        logic         dirty;
    } fill_t;

    typedef struct {
        int          due;
        logic [31:0] data;
    } resp_t;

    req_t       expReq[$];
    fill_t      expFill[$];
    logic [3:0] expDone[$];
    resp_t      pend[$];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int readyMode = 0;
    int latency = 1;
    int respDelivered = 0;
    int fillEvents = 0;
    int freeEvents = 0;

    task automatic checkOutput(input string name, input logic [159:0] actual, input logic [159:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    always @(posedge CLK) cyc <= cyc + 1;

    // Memory model: reads return 0xA0 + word offset after a fixed latency, in order.
    always @(negedge CLK) begin
        if (!RST && mem_req_valid && mem_req_ready && !mem_req_rw) begin
            pend.push_back('{due: cyc + latency, data: 32'hA0 + 32'(mem_req_addr[3:2])});
        end
    end

    initial begin
        mem_req_ready  = 1'b1;
        mem_resp_valid = 1'b0;
        mem_resp_rdata = '0;
        forever begin
            @(posedge CLK);
            #1;
            mem_req_ready = (readyMode == 0) ? 1'b1 : cyc[0];
            if (pend.size() > 0 && pend[0].due <= cyc) begin
                mem_resp_valid = 1'b1;
                mem_resp_rdata = pend[0].data;
                void'(pend.pop_front());
                respDelivered++;
            end else begin
                mem_resp_valid = 1'b0;
                mem_resp_rdata = '0;
            end
        end
    end

    req_t  monReq;
    fill_t monFill;
    string monName;

    always @(negedge CLK) begin
        if (!RST) begin
            if (mem_req_valid) begin
                if (expReq.size() == 0) begin
                    checkOutput("mem_req_unexpected", 160'(mem_req_valid), 160'(0));
                end else begin
                    monReq  = expReq[0];
                    monName = mem_req_ready ? "mem_req_beat" : "mem_req_stalled";
                    checkOutput(monName,
                                160'({mem_req_rw, mem_req_addr, mem_req_rw ? mem_req_wdata : 32'd0}),
                                160'({monReq.rw, monReq.addr, monReq.rw ? monReq.wdata : 32'd0}));
                    if (mem_req_ready) void'(expReq.pop_front());
                end
            end
            if (fill_en) begin
                fillEvents++;
                if (expFill.size() == 0) begin
                    checkOutput("fill_unexpected", 160'(fill_en), 160'(0));
                end else begin
                    monFill = expFill.pop_front();
                    checkOutput("fill", 160'({fill_index, fill_tag, fill_block, fill_dirty}),
                                160'({monFill.index, monFill.tag, monFill.block, monFill.dirty}));
                end
            end
            if (bank_free) begin
                freeEvents++;
                if (expDone.size() == 0) begin
                    checkOutput("bank_free_unexpected", 160'(bank_free), 160'(0));
                end else begin
                    checkOutput("done_uuid", 160'(done_uuid), 160'(expDone.pop_front()));
                end
            end
        end
    end

    task automatic applyStimulus(input logic [3:0] uuid, input logic [31:0] blockAddr,
                                 input logic [3:0] ws, input logic [127:0] wBlock,
                                 input logic vValid, input logic vDirty, input logic [25:0] vTag,
                                 input logic [127:0] vBlock, input logic [31:0] wbAddr,
                                 input logic [1:0] expIndex, input logic [25:0] expTag,
                                 input logic [127:0] expBlock, input logic expDirty,
                                 output int startCyc);
        @(posedge CLK);
        #1;
        mshr_valid        = 1'b1;
        mshr_uuid         = uuid;
        mshr_block_addr   = blockAddr;
        mshr_write_status = ws;
        mshr_write_block  = wBlock;
        victim_valid      = vValid;
        victim_dirty      = vDirty;
        victim_tag        = vTag;
        victim_block      = vBlock;
        if (vValid && vDirty) begin
            for (int i = 0; i < BLOCK_SIZE; i++) begin
                expReq.push_back('{rw: 1'b1, addr: wbAddr + 32'(4 * i), wdata: vBlock[i*32 +: 32]});
            end
        end
        for (int i = 0; i < BLOCK_SIZE; i++) begin
            expReq.push_back('{rw: 1'b0, addr: blockAddr + 32'(4 * i), wdata: 32'd0});
        end
        expFill.push_back('{index: expIndex, tag: expTag, block: expBlock, dirty: expDirty});
        expDone.push_back(uuid);
        startCyc = cyc;
    endtask

    task automatic waitFree(output int freeCyc);
        int found;
        found   = 0;
        freeCyc = -1;
        for (int n = 0; n < 200; n++) begin
            @(negedge CLK);
            if (bank_free) begin
                freeCyc = cyc;
                found   = 1;
                break;
            end
        end
        if (found == 0) checkOutput("bank_free_timeout", 160'(bank_free), 160'(1));
    endtask

    task automatic releaseEntry();
        @(posedge CLK);
        #1;
        mshr_valid   = 1'b0;
        victim_valid = 1'b0;
        victim_dirty = 1'b0;
        checkOutput("req_queue_drained", 160'(expReq.size()), 160'(0));
        checkOutput("fill_queue_drained", 160'(expFill.size()), 160'(0));
        @(negedge CLK);
        checkOutput("idle_after_retire", 160'(busy), 160'(0));
    endtask

    task automatic waitPendEmpty();
        for (int n = 0; n < 100; n++) begin
            if (pend.size() == 0) break;
            @(posedge CLK);
        end
        checkOutput("mem_drain", 160'(pend.size()), 160'(0));
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    int s0, f0, s1, f1, baseResp, baseFill, baseFree, gotResp;

    initial begin
        mshr_valid        = 1'b0;
        mshr_uuid         = '0;
        mshr_block_addr   = '0;
        mshr_write_status = '0;
        mshr_write_block  = '0;
        victim_valid      = 1'b0;
        victim_dirty      = 1'b0;
        victim_tag        = '0;
        victim_block      = '0;
        RST               = 1'b1;

        repeat (3) @(posedge CLK);
        @(negedge CLK);
        checkOutput("reset_busy", 160'(busy), 160'(0));
        checkOutput("reset_mem_req_valid", 160'(mem_req_valid), 160'(0));
        checkOutput("reset_fill_en", 160'(fill_en), 160'(0));
        checkOutput("reset_bank_free", 160'(bank_free), 160'(0));
        checkOutput("reset_outputs", 160'({mem_req_addr, done_uuid, fill_block[31:0]}), 160'(0));
        @(posedge CLK);
        #1;
        RST = 1'b0;
        repeat (2) @(posedge CLK);

        $display("[TB] clean miss, no stores");
        applyStimulus(4'd1, 32'h100, 4'b0000, 128'd0, 1'b1, 1'b0, 26'h7,
                      {32'hC3, 32'hC2, 32'hC1, 32'hC0}, 32'h0, 2'd0, 26'h4,
                      {32'hA3, 32'hA2, 32'hA1, 32'hA0}, 1'b0, s0);
        waitFree(f0);
        checkOutput("clean_free_cycle", 160'(f0 - s0), 160'(7));
        releaseEntry();

        $display("[TB] dirty victim writeback");
        applyStimulus(4'd2, 32'h1230, 4'b0000, 128'd0, 1'b1, 1'b1, 26'h3,
                      {32'hD3, 32'hD2, 32'hD1, 32'hD0}, 32'hF0, 2'd3, 26'h48,
                      {32'hA3, 32'hA2, 32'hA1, 32'hA0}, 1'b0, s0);
        waitFree(f0);
        checkOutput("dirty_free_cycle", 160'(f0 - s0), 160'(11));
        releaseEntry();

        $display("[TB] store merge");
        applyStimulus(4'd3, 32'h100, 4'b0101, {32'hEE, 32'h33, 32'hEE, 32'h11}, 1'b0, 1'b0, 26'h0,
                      128'd0, 32'h0, 2'd0, 26'h4,
                      {32'hA3, 32'h33, 32'hA1, 32'h11}, 1'b1, s0);
        waitFree(f0);
        checkOutput("merge_free_cycle", 160'(f0 - s0), 160'(7));
        releaseEntry();

        $display("[TB] backpressure with latency 3");
        readyMode = 1;
        latency   = 3;
        applyStimulus(4'd4, 32'h200, 4'b1000, {32'h44, 32'h0, 32'h0, 32'h0}, 1'b1, 1'b1, 26'h5,
                      {32'hE3, 32'hE2, 32'hE1, 32'hE0}, 32'h140, 2'd0, 26'h8,
                      {32'h44, 32'hA2, 32'hA1, 32'hA0}, 1'b1, s0);
        waitFree(f0);
        releaseEntry();
        readyMode = 0;
        latency   = 1;
        waitPendEmpty();

        $display("[TB] reset during fetch");
        baseFill = fillEvents;
        baseFree = freeEvents;
        baseResp = respDelivered;
        gotResp  = 0;
        applyStimulus(4'd7, 32'h300, 4'b0000, 128'd0, 1'b0, 1'b0, 26'h0, 128'd0, 32'h0,
                      2'd0, 26'hC, {32'hA3, 32'hA2, 32'hA1, 32'hA0}, 1'b0, s0);
        for (int n = 0; n < 50; n++) begin
            @(negedge CLK);
            if (respDelivered - baseResp >= 2) begin
                gotResp = 1;
                break;
            end
        end
        if (gotResp == 0) checkOutput("rst_resp_timeout", 160'(respDelivered - baseResp), 160'(2));
        @(posedge CLK);
        #1;
        RST          = 1'b1;
        mshr_valid   = 1'b0;
        victim_valid = 1'b0;
        expReq.delete();
        expFill.delete();
        expDone.delete();
        @(negedge CLK);
        checkOutput("rst_busy", 160'(busy), 160'(0));
        checkOutput("rst_mem_req_valid", 160'(mem_req_valid), 160'(0));
        repeat (2) @(posedge CLK);
        #1;
        RST = 1'b0;
        repeat (8) @(negedge CLK);
        checkOutput("post_rst_busy", 160'(busy), 160'(0));
        checkOutput("post_rst_no_fill", 160'(fillEvents - baseFill), 160'(0));
        checkOutput("post_rst_no_free", 160'(freeEvents - baseFree), 160'(0));
        waitPendEmpty();

        $display("[TB] back-to-back entries");
        applyStimulus(4'd5, 32'h100, 4'b0000, 128'd0, 1'b0, 1'b0, 26'h0, 128'd0, 32'h0,
                      2'd0, 26'h4, {32'hA3, 32'hA2, 32'hA1, 32'hA0}, 1'b0, s0);
        waitFree(f0);
        applyStimulus(4'd6, 32'h210, 4'b0000, 128'd0, 1'b0, 1'b0, 26'h0, 128'd0, 32'h0,
                      2'd1, 26'h8, {32'hA3, 32'hA2, 32'hA1, 32'hA0}, 1'b0, s1);
        checkOutput("b2b_latch_cycle", 160'(s1 - f0), 160'(1));
        waitFree(f1);
        checkOutput("b2b_free_spacing", 160'(f1 - f0), 160'(8));
        releaseEntry();
        checkOutput("done_queue_drained", 160'(expDone.size()), 160'(0));

        repeat (3) @(posedge CLK);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cache_bank_miss_handler.md
# cache_bank_miss_handler

Per-bank miss retirement engine for the cache bank, sitting downstream of the MSHR buffer. It accepts the head MSHR entry, writes back a dirty victim, and fetches the missing block from memory one word per beat. It then merges the buffered store words into the fetched data, writes the block into the bank arrays, and pulses `bank_free` so the MSHR buffer pops the entry.

## Interface
- `WORD_W`, 32, data word width
- `BLOCK_SIZE`, 4, words per block; must be a power of 2
- `ADDR_W`, 32, byte address width
- `TAG_W`, 26, tag width
- `INDEX_W`, 2, set index width; `TAG_W + INDEX_W + log2(BLOCK_SIZE) + 2 == ADDR_W`
- `UUID_SIZE`, 4, request id width

Ports:
- `CLK`  in  1  clock, rising edge
- `RST`  in  1  reset, asynchronous, active-high
- `mshr_valid`  in  1  head MSHR entry valid
- `mshr_uuid`  in  UUID_SIZE  entry uuid
- `mshr_block_addr`  in  ADDR_W  block-aligned miss address
- `mshr_write_status`  in  BLOCK_SIZE  per-word store mask
- `mshr_write_block`  in  BLOCK_SIZE*WORD_W  buffered store words; word i at bits [i*WORD_W +: WORD_W]
- `bank_free`  out  1  one-cycle pulse that pops the head entry
- `victim_valid`, `victim_dirty`  in  1 each  state of the victim way at the latched index
- `victim_tag`  in  TAG_W  victim tag
- `victim_block`  in  BLOCK_SIZE*WORD_W  victim data
- `mem_req_valid`  out  1  memory request beat valid
- `mem_req_ready`  in  1  memory accepts the beat
- `mem_req_rw`  out  1  1 = write, 0 = read
- `mem_req_addr`  out  ADDR_W  word address of the beat
- `mem_req_wdata`  out  WORD_W  write data of the beat
- `mem_resp_valid`  in  1  read response beat; responses return in order
- `mem_resp_rdata`  in  WORD_W  read data
- `fill_en`  out  1  bank array write strobe
- `fill_index`  out  INDEX_W  set index to write
- `fill_tag`  out  TAG_W  tag to write
- `fill_block`  out  BLOCK_SIZE*WORD_W  merged block
- `fill_dirty`  out  1  dirty bit to write; equals `|write_status`
- `done_uuid`  out  UUID_SIZE  uuid of the retired entry; valid while `bank_free` is high
- `busy`  out  1  FSM is not in IDLE

## Operation
- FSM states: IDLE, WB, FETCH, FILL, RETIRE.
- **IDLE**
  - When `mshr_valid` is high, latch uuid, block_addr, write_status and write_block.
  - Next state is WB if `victim_valid && victim_dirty`, otherwise FETCH.
  - Victim inputs are sampled in this same cycle and the victim block is latched.
- **WB**
  - Issues BLOCK_SIZE write beats with `mem_req_rw=1`.
  - `mem_req_addr = {victim_tag, index, beat, 2'b00}`; `mem_req_wdata` is victim word `beat`.
  - The beat counter advances only on `mem_req_valid && mem_req_ready`.
  - After the last accepted beat the FSM goes to FETCH. Writes produce no response.
- **FETCH**
  - Issues BLOCK_SIZE read beats to `block_addr + 4*beat`, counted by the issue counter.
  - A separate receive counter stores each `mem_resp_rdata` into word slot `rcv`.
  - `mem_req_valid` drops once all beats are issued.
  - When the receive counter reaches BLOCK_SIZE the FSM goes to FILL.
  - A response may arrive in the same cycle its request is accepted.
- **FILL**
  - `fill_en=1` for exactly one cycle.
  - Word i of `fill_block` = `write_status[i]` ? store word i : fetched word i.
  - `fill_tag` and `fill_index` come from the latched `block_addr`; `fill_dirty = |write_status`.
- **RETIRE**
  - `bank_free=1` and `done_uuid` = latched uuid for one cycle, then IDLE.
  - The MSHR head stays stable until this pop.
- While the FSM is not in IDLE, `mshr_valid` is ignored and no new entry is latched.
- `mem_resp_valid` is ignored outside FETCH.
- Counters are log2(BLOCK_SIZE)+1 bits wide; beat addresses never cross the block boundary.

## Timing
- Reset drives FSM to IDLE; all counters and latched fields to 0; all outputs to 0.
- Asserting `RST` mid-operation aborts immediately: no `fill_en` or `bank_free` is produced, and late memory responses are dropped.
- Clean miss with `mem_req_ready=1` and response latency 1:
  - Latch in cycle 0.
  - Requests in cycles 1..BLOCK_SIZE.
  - Last response in cycle BLOCK_SIZE+1.
  - FILL in cycle BLOCK_SIZE+2, RETIRE in cycle BLOCK_SIZE+3.
- A dirty victim adds BLOCK_SIZE cycles (WB) when `mem_req_ready=1`.
- Request handshake: `mem_req_valid`, `mem_req_addr` and `mem_req_wdata` are held stable until `mem_req_ready` is sampled high.
- Back-to-back entries: the earliest next latch is the cycle after RETIRE, giving a minimum of one IDLE cycle between entries.

## Test plan
- **Clean miss, no stores.** Block_addr 0x100, victim clean, memory returns 0xA0..0xA3 → read beats to 0x100, 0x104, 0x108, 0x10C; fill_block = A0..A3; fill_dirty=0; bank_free at cycle 7.
- **Dirty victim.** Victim tag 0x3 with data 0xD0..0xD3 → 4 writes to the victim address with data D0..D3 precede the reads; then fill.
- **Store merge.** write_status=4'b0101, stores 0x11 (word 0) and 0x33 (word 2) → fill_block = {A3, 0x33, A1, 0x11} (word 3 down to word 0); fill_dirty=1.
- **Backpressure.** `mem_req_ready` toggles every cycle with response latency 3 → addresses and data stay stable while stalled; exactly 4 reads; correct fill.
- **Reset mid-FETCH.** `RST` high after 2 responses, then responses continue → no fill_en and no bank_free; IDLE; busy=0.
- **Back-to-back entries.** Two entries with uuid 5 and 6 → done_uuid 5 then 6, each with a one-cycle bank_free pulse.
